// File: rtl/dm_pkg.sv
// Shared encodings for the wait-state data memory: access controls, fault codes, FSM states
// and the load-extension helper.
package dm_pkg;

    localparam logic [2:0] DM_BYTE  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_WORD  = 3'b010;
    localparam logic [2:0] DM_BYTEU = 3'b100;
    localparam logic [2:0] DM_HALFU = 3'b101;

    typedef enum logic [1:0] {
        FaultNone     = 2'b00,
        FaultMisalign = 2'b01,
        FaultRange    = 2'b10,
        FaultCtrl     = 2'b11
    } dm_fault_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } dm_state_e;

    // Byte lanes touched by an access of the given width.
    function automatic logic [3:0] dm_lane_mask(input logic [2:0] ctrl);
        case (ctrl[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] dm_load_format(input logic [2:0] ctrl, input logic [31:0] raw);
        case (ctrl)
            DM_BYTE:  return {{24{raw[7]}}, raw[7:0]};
            DM_HALF:  return {{16{raw[15]}}, raw[15:0]};
            DM_BYTEU: return {24'd0, raw[7:0]};
            DM_HALFU: return {16'd0, raw[15:0]};
            default:  return raw;
        endcase
    endfunction

endpackage

// File: rtl/dm_wait_ctrl_if.sv
// Request/ready/valid handshake between the execute stage and the data memory.
interface dm_wait_ctrl_if;

    logic        DMReq;
    logic        DMWrEnable;
    logic [2:0]  DMCtrl;
    logic [31:0] DMAddress;
    logic [31:0] DMDataIn;
    logic        DMReady;
    logic        DMValid;
    logic [31:0] DMDataOut;
    logic [1:0]  DMFault;

    modport master (
        output DMReq, DMWrEnable, DMCtrl, DMAddress, DMDataIn,
        input  DMReady, DMValid, DMDataOut, DMFault
    );

    modport slave (
        input  DMReq, DMWrEnable, DMCtrl, DMAddress, DMDataIn,
        output DMReady, DMValid, DMDataOut, DMFault
    );

endinterface

// File: rtl/dm_byte_array.sv
// Byte-wide storage with four lanes at consecutive (wrapping) addresses; synchronous lane
// writes, combinational 4-byte read. Contents are not reset.
module dm_byte_array #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            we_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [7:0]            mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] lane_addr [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr_i + ADDR_WIDTH'(i);
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 4; i++) begin
            rdata_o[8*i +: 8] = mem[lane_addr[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem[lane_addr[i]] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_wait_ctrl.sv
// Data memory front end: accepts one request, waits WAIT_STATES cycles, commits the access
// with fault checking and load extension, then pulses DMValid for one cycle.
module dm_wait_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    dm_wait_ctrl_if.slave    dm
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    dm_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dout_q, dout_d;
    dm_fault_e   fault_q, fault_d;

    dm_fault_e   fault_now;
    logic        accept, commit;
    logic [3:0]  lane_we;
    logic [31:0] rdata;
    logic [32:0] last_byte;
    logic        illegal, out_of_range, misaligned;

    assign accept = dm.DMReq & dm.DMReady;
    assign commit = (state_q == StWait) && (cnt_q == 4'd0);

    // Fault classification of the latched request, highest priority first.
    always_comb begin
        last_byte    = {1'b0, addr_q} + ((ctrl_q[1:0] == 2'b00) ? 33'd0 :
                                         (ctrl_q[1:0] == 2'b01) ? 33'd1 : 33'd3);
        illegal      = (ctrl_q == 3'b011) || (ctrl_q[2:1] == 2'b11) || (wr_q && ctrl_q[2]);
        out_of_range = ((addr_q >> ADDR_WIDTH) != 32'd0) ||
                       (ALIGN_CHECK && ((last_byte >> ADDR_WIDTH) != 33'd0));
        misaligned   = ALIGN_CHECK &&
                       (((ctrl_q[1:0] == 2'b01) && addr_q[0]) ||
                        ((ctrl_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)));
        if (illegal) begin
            fault_now = FaultCtrl;
        end else if (out_of_range) begin
            fault_now = FaultRange;
        end else if (misaligned) begin
            fault_now = FaultMisalign;
        end else begin
            fault_now = FaultNone;
        end
    end

    dm_byte_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .addr_i  (addr_q[ADDR_WIDTH-1:0]),
        .we_i    (lane_we),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            ctrl_q  <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            dout_q  <= 32'd0;
            fault_q <= FaultNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                    wr_d    = dm.DMWrEnable;
                    ctrl_d  = dm.DMCtrl;
                    addr_d  = dm.DMAddress;
                    wdata_d = dm.DMDataIn;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    fault_d = fault_now;
                    dout_d  = (!wr_q && (fault_now == FaultNone)) ?
                              dm_load_format(ctrl_q, rdata) : 32'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dm.DMReady   = (state_q != StWait);
        dm.DMValid   = (state_q == StResp);
        dm.DMDataOut = dout_q;
        dm.DMFault   = fault_q;
        lane_we      = (commit && wr_q && (fault_now == FaultNone)) ? dm_lane_mask(ctrl_q) : 4'd0;
    end

endmodule
